// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state type and default sizes for the UART TX arbiter
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus UART data_in/transmit/tx_busy and arbiter status
interface uart_tx_arbiter_if import uart_tx_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic [DATA_W-1:0] tx_data_in;
  logic tx_transmit;
  logic tx_busy;
  logic [$clog2(NUM_REQ)-1:0] grant_id;
  logic active;
  logic timeout_err;
  modport slave (
    input req_valid, req_data, tx_busy,
    output req_ready, tx_data_in, tx_transmit, grant_id, active, timeout_err
  );
  modport master (
    output req_valid, req_data, tx_busy,
    input req_ready, tx_data_in, tx_transmit, grant_id, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// uart_tx_arbiter_rr: combinational round-robin pick, first valid index after ptr with wrap
module uart_tx_arbiter_rr import uart_tx_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic any_valid
);
  localparam int IW = $clog2(NUM_REQ);
  logic hit;
  logic [IW-1:0] j;
  always_comb begin
    hit = 1'b0;
    idx = '0;
    j = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (!hit && valid[j]) begin
        hit = 1'b1;
        idx = j;
      end
    end
  end
  assign any_valid = hit;
  assign onehot = hit ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX among NUM_REQ byte sources (clk, reset, bus slave)
module uart_tx_arbiter import uart_tx_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BUSY_TIMEOUT = 64
) (
  input logic clk,
  input logic reset,
  uart_tx_arbiter_if.slave b
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;
  state_t state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [NUM_REQ-1:0] win;
  logic [IW-1:0] widx;
  logic any;
  uart_tx_arbiter_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid(b.req_valid),
    .ptr(ptr),
    .onehot(win),
    .idx(widx),
    .any_valid(any)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr <= IW'(NUM_REQ - 1);
      cnt <= '0;
      b.req_ready <= '0;
      b.tx_data_in <= '0;
      b.tx_transmit <= 1'b0;
      b.grant_id <= '0;
      b.active <= 1'b0;
      b.timeout_err <= 1'b0;
    end else begin
      b.req_ready <= '0;
      b.timeout_err <= 1'b0;
      case (state)
        IDLE: if (any && !b.tx_busy) begin
          b.req_ready <= win;
          b.tx_data_in <= b.req_data[widx*DATA_W +: DATA_W];
          b.grant_id <= widx;
          ptr <= widx;
          b.tx_transmit <= 1'b1;
          b.active <= 1'b1;
          cnt <= '0;
          state <= LOAD;
        end
        LOAD: if (b.tx_busy) begin
          b.tx_transmit <= 1'b0;
          state <= WAIT_DONE;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          b.tx_transmit <= 1'b0;
          b.active <= 1'b0;
          b.timeout_err <= 1'b1;
          state <= IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        WAIT_DONE: if (!b.tx_busy) begin
          b.active <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
